// File: rtl/pmp_dmp_pkg.sv
// Shared types and helpers for the registered multi-port PMP/DMP checker.
// Covers access/privilege encodings, pmpcfg/dmpcfg layouts and the response bundle.
package pmp_dmp_pkg;

    localparam int unsigned MAX_ENTRIES = 64;
    localparam int unsigned MAX_PORTS   = 4;

    typedef logic [2:0] pmp_access_t;
    localparam pmp_access_t ACCESS_NONE  = 3'b000;
    localparam pmp_access_t ACCESS_READ  = 3'b001;
    localparam pmp_access_t ACCESS_WRITE = 3'b010;
    localparam pmp_access_t ACCESS_EXEC  = 3'b100;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } pmp_addr_mode_t;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmp_access_t    access_type;
    } pmpcfg_t;

    typedef logic [3:0] dmp_domain_t;
    // Domain value that matches any other domain
    localparam dmp_domain_t DOMI = 4'h0;

    typedef struct packed {
        logic [3:0]  reserved;
        dmp_domain_t domain;
    } dmpcfg_t;

    typedef struct packed {
        logic       allow;
        logic       hit;
        logic [5:0] entry_idx;
    } pmp_dmp_resp_t;

    function automatic logic dom_permitted(dmp_domain_t entry_dom,
                                           dmp_domain_t req_dom);
        return (entry_dom == DOMI) || (req_dom == DOMI) ||
               (entry_dom == req_dom);
    endfunction

endpackage

// File: rtl/pmp_dmp_lookup.sv
// Combinational priority scan of all PMP/DMP entries for one request.
// The lowest-indexed eligible matching entry decides the result.
module pmp_dmp_lookup
    import pmp_dmp_pkg::*;
#(
    parameter int unsigned PLEN       = 34,
    parameter int unsigned PMP_LEN    = 32,
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned NE         = (NR_ENTRIES > 0) ? NR_ENTRIES : 1
) (
    input  logic [PLEN-1:0]            addr,
    input  pmp_access_t                access,
    input  priv_lvl_t                  priv,
    input  dmp_domain_t                dom,
    input  logic [NE-1:0][PMP_LEN-1:0] conf_addr,
    input  pmpcfg_t [NE-1:0]           pmpconf,
    input  dmpcfg_t [NE-1:0]           dmpconf,
    output pmp_dmp_resp_t              resp
);

    localparam int unsigned AW = (PLEN > PMP_LEN + 2) ? PLEN : PMP_LEN + 2;

    logic [AW-1:0] a;
    logic [NE-1:0] match;
    logic          found;
    logic          unused_cfg;

    assign a = AW'(addr);

    for (genvar i = 0; i < NE; i++) begin : g_ent
        logic [AW-1:0] hi;
        logic [AW-1:0] lo;
        logic [AW-1:0] x;
        logic [AW-1:0] m;

        assign hi = AW'({conf_addr[i], 2'b00});
        if (i == 0) begin : g_first
            assign lo = '0;
        end else begin : g_rest
            assign lo = AW'({conf_addr[i-1], 2'b00});
        end
        // NAPOT: the trailing ones of {pmpaddr,2'b11} mark the ignored bits
        assign x = AW'({conf_addr[i], 2'b11});
        assign m = x ^ (x + AW'(1));

        always_comb begin
            match[i] = 1'b0;
            unique case (pmpconf[i].addr_mode)
                OFF:   match[i] = 1'b0;
                TOR:   match[i] = (a >= lo) && (a < hi);
                NA4:   match[i] = (a[AW-1:2] == hi[AW-1:2]);
                NAPOT: match[i] = ((a & ~m) == (x & ~m));
            endcase
        end
    end

    always_comb begin
        resp  = '0;
        found = 1'b0;
        for (int i = 0; i < NE; i++) begin
            if (NR_ENTRIES > 0 && !found && match[i] &&
                (priv != PRIV_LVL_M || pmpconf[i].locked)) begin
                found          = 1'b1;
                resp.hit       = 1'b1;
                resp.entry_idx = 6'(i);
                resp.allow     = ((access & ~pmpconf[i].access_type) == 3'b000) &&
                                 dom_permitted(dmpconf[i].domain, dom);
            end
        end
        if (!found) begin
            resp.allow = (NR_ENTRIES == 0) || (priv == PRIV_LVL_M);
        end
    end

    always_comb begin
        unused_cfg = 1'b0;
        for (int i = 0; i < NE; i++) begin
            unused_cfg = unused_cfg ^ (^pmpconf[i].reserved) ^ (^dmpconf[i].reserved);
        end
    end

endmodule

// File: rtl/pmp_dmp_checker.sv
// Registered multi-port PMP/DMP checker with one-cycle latency per port,
// a sticky first-fault record and a saturating denial counter.
module pmp_dmp_checker
    import pmp_dmp_pkg::*;
#(
    parameter int unsigned PLEN       = 34,
    parameter int unsigned PMP_LEN    = 32,
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned NR_PORTS   = 2,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned NE        = (NR_ENTRIES > 0) ? NR_ENTRIES : 1,
    localparam int unsigned PW        = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NR_PORTS-1:0]              req_valid_i,
    output logic [NR_PORTS-1:0]              req_ready_o,
    input  logic [NR_PORTS-1:0][PLEN-1:0]    req_addr_i,
    input  pmp_access_t [NR_PORTS-1:0]       req_access_i,
    input  priv_lvl_t [NR_PORTS-1:0]         req_priv_i,
    input  dmp_domain_t [NR_PORTS-1:0]       req_dom_i,
    output logic [NR_PORTS-1:0]              resp_valid_o,
    input  logic [NR_PORTS-1:0]              resp_ready_i,
    output pmp_dmp_resp_t [NR_PORTS-1:0]     resp_o,
    input  logic [NE-1:0][PMP_LEN-1:0]       conf_addr_i,
    input  pmpcfg_t [NE-1:0]                 pmpconf_i,
    input  dmpcfg_t [NE-1:0]                 dmpconf_i,
    input  logic                             cfg_update_i,
    output logic                             fault_valid_o,
    output logic [PLEN-1:0]                  fault_addr_o,
    output logic [PW-1:0]                    fault_port_o,
    output dmp_domain_t                      fault_dom_o,
    input  logic                             fault_clear_i,
    output logic [CNT_W-1:0]                 fault_cnt_o
);

    localparam int unsigned SW = CNT_W + 3;

    pmp_dmp_resp_t [NR_PORTS-1:0] lk;
    logic [NR_PORTS-1:0]          accept;
    logic [NR_PORTS-1:0]          deny;
    logic [2:0]                   n_deny;
    logic [PW-1:0]                sel_port;
    logic [PLEN-1:0]              sel_addr;
    dmp_domain_t                  sel_dom;
    logic [CNT_W-1:0]             cnt_base;
    logic [SW-1:0]                cnt_sum;
    logic [CNT_W-1:0]             cnt_next;

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
        pmp_dmp_lookup #(
            .PLEN       (PLEN),
            .PMP_LEN    (PMP_LEN),
            .NR_ENTRIES (NR_ENTRIES),
            .NE         (NE)
        ) u_lookup (
            .addr      (req_addr_i[p]),
            .access    (req_access_i[p]),
            .priv      (req_priv_i[p]),
            .dom       (req_dom_i[p]),
            .conf_addr (conf_addr_i),
            .pmpconf   (pmpconf_i),
            .dmpconf   (dmpconf_i),
            .resp      (lk[p])
        );

        assign req_ready_o[p] = !cfg_update_i &&
                                (!resp_valid_o[p] || resp_ready_i[p]);
        assign accept[p]      = req_valid_i[p] && req_ready_o[p];
        assign deny[p]        = accept[p] && !lk[p].allow;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_o <= '0;
            resp_o       <= '0;
        end else begin
            for (int p = 0; p < NR_PORTS; p++) begin
                if (accept[p]) begin
                    resp_valid_o[p] <= 1'b1;
                    resp_o[p]       <= lk[p];
                end else if (resp_ready_i[p]) begin
                    resp_valid_o[p] <= 1'b0;
                end
            end
        end
    end

    // Walk downwards so the lowest denying port ends up selected
    always_comb begin
        n_deny   = '0;
        sel_port = '0;
        sel_addr = '0;
        sel_dom  = '0;
        for (int p = NR_PORTS - 1; p >= 0; p--) begin
            n_deny = n_deny + 3'(deny[p]);
            if (deny[p]) begin
                sel_port = PW'(p);
                sel_addr = req_addr_i[p];
                sel_dom  = req_dom_i[p];
            end
        end
    end

    always_comb begin
        cnt_base = fault_clear_i ? '0 : fault_cnt_o;
        cnt_sum  = SW'(cnt_base) + SW'(n_deny);
        cnt_next = (cnt_sum > SW'({CNT_W{1'b1}})) ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_valid_o <= 1'b0;
            fault_addr_o  <= '0;
            fault_port_o  <= '0;
            fault_dom_o   <= '0;
            fault_cnt_o   <= '0;
        end else begin
            fault_cnt_o <= cnt_next;
            if ((|deny) && (!fault_valid_o || fault_clear_i)) begin
                fault_valid_o <= 1'b1;
                fault_addr_o  <= sel_addr;
                fault_port_o  <= sel_port;
                fault_dom_o   <= sel_dom;
            end else if (fault_clear_i) begin
                fault_valid_o <= 1'b0;
                fault_addr_o  <= '0;
                fault_port_o  <= '0;
                fault_dom_o   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pmp_dmp_checker.sv
// Bench for pmp_dmp_checker: directed steps plus random traffic checked
// against a region-arithmetic reference model of the permission rules.
module tb_pmp_dmp_checker;
    import pmp_dmp_pkg::*;

    localparam int NP  = 2;
    localparam int NEN = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]             req_valid;
    logic [NP-1:0]             req_ready;
    logic [NP-1:0][33:0]       req_addr;
    pmp_access_t [NP-1:0]      req_access;
    priv_lvl_t [NP-1:0]        req_priv;
    dmp_domain_t [NP-1:0]      req_dom;
    logic [NP-1:0]             resp_valid;
    logic [NP-1:0]             resp_ready;
    pmp_dmp_resp_t [NP-1:0]    resp;
    logic [NEN-1:0][31:0]      conf_addr;
    pmpcfg_t [NEN-1:0]         pmpconf;
    dmpcfg_t [NEN-1:0]         dmpconf;
    logic                      cfg_update;
    logic                      fault_valid;
    logic [33:0]               fault_addr;
    logic [0:0]                fault_port;
    dmp_domain_t               fault_dom;
    logic                      fault_clear;
    logic [15:0]               fault_cnt;

    // Single-port instances: 1 entry with a 2-bit counter, and 0 entries
    logic [0:0]          s_valid, s_ready, s_rvalid, s_rready, s_fport;
    logic [0:0][33:0]    s_addr;
    pmp_access_t [0:0]   s_acc;
    priv_lvl_t [0:0]     s_priv;
    dmp_domain_t [0:0]   s_dom;
    pmp_dmp_resp_t [0:0] s_resp;
    logic [0:0][31:0]    s_conf;
    pmpcfg_t [0:0]       s_pcfg;
    dmpcfg_t [0:0]       s_dcfg;
    logic                s_fvalid;
    logic [33:0]         s_faddr;
    dmp_domain_t         s_fdom;
    logic [1:0]          s_cnt;

    logic [0:0]          z_valid, z_ready, z_rvalid, z_fport;
    logic [0:0][33:0]    z_addr;
    pmp_access_t [0:0]   z_acc;
    priv_lvl_t [0:0]     z_priv;
    dmp_domain_t [0:0]   z_dom;
    pmp_dmp_resp_t [0:0] z_resp;
    logic                z_fvalid;
    logic [33:0]         z_faddr;
    dmp_domain_t         z_fdom;
    logic [15:0]         z_cnt;

    pmp_dmp_checker #(.NR_ENTRIES(NEN), .NR_PORTS(NP), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_access_i(req_access),
        .req_priv_i(req_priv), .req_dom_i(req_dom),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_o(resp),
        .conf_addr_i(conf_addr), .pmpconf_i(pmpconf), .dmpconf_i(dmpconf),
        .cfg_update_i(cfg_update),
        .fault_valid_o(fault_valid), .fault_addr_o(fault_addr),
        .fault_port_o(fault_port), .fault_dom_o(fault_dom),
        .fault_clear_i(fault_clear), .fault_cnt_o(fault_cnt)
    );

    pmp_dmp_checker #(.NR_ENTRIES(1), .NR_PORTS(1), .CNT_W(2)) dut_s (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(s_valid), .req_ready_o(s_ready),
        .req_addr_i(s_addr), .req_access_i(s_acc),
        .req_priv_i(s_priv), .req_dom_i(s_dom),
        .resp_valid_o(s_rvalid), .resp_ready_i(s_rready), .resp_o(s_resp),
        .conf_addr_i(s_conf), .pmpconf_i(s_pcfg), .dmpconf_i(s_dcfg),
        .cfg_update_i(1'b0),
        .fault_valid_o(s_fvalid), .fault_addr_o(s_faddr),
        .fault_port_o(s_fport), .fault_dom_o(s_fdom),
        .fault_clear_i(1'b0), .fault_cnt_o(s_cnt)
    );

    pmp_dmp_checker #(.NR_ENTRIES(0), .NR_PORTS(1), .CNT_W(16)) dut_z (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(z_valid), .req_ready_o(z_ready),
        .req_addr_i(z_addr), .req_access_i(z_acc),
        .req_priv_i(z_priv), .req_dom_i(z_dom),
        .resp_valid_o(z_rvalid), .resp_ready_i(1'b1), .resp_o(z_resp),
        .conf_addr_i(s_conf), .pmpconf_i(s_pcfg), .dmpconf_i(s_dcfg),
        .cfg_update_i(1'b0),
        .fault_valid_o(z_fvalid), .fault_addr_o(z_faddr),
        .fault_port_o(z_fport), .fault_dom_o(z_fdom),
        .fault_clear_i(1'b0), .fault_cnt_o(z_cnt)
    );

    int ncmp  = 0;
    int nfail = 0;

    logic          mv [NP];
    pmp_dmp_resp_t mr [NP];
    logic          fv;
    logic [33:0]   fa;
    int            fp;
    dmp_domain_t   fd;
    int            mcnt;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each entry is turned into a byte range [lo,hi) and searched in order
    function automatic pmp_dmp_resp_t ref_lookup(longint unsigned a,
                                                 pmp_access_t acc,
                                                 priv_lvl_t pv,
                                                 dmp_domain_t dom);
        pmp_dmp_resp_t r;
        longint unsigned lo, hi, size, base;
        int t;
        r = '0;
        for (int i = 0; i < NEN; i++) begin
            if (pv == PRIV_LVL_M && !pmpconf[i].locked) continue;
            base = 64'(conf_addr[i]) * 4;
            lo = 1;
            hi = 0;
            case (pmpconf[i].addr_mode)
                TOR: begin
                    lo = (i == 0) ? 0 : 64'(conf_addr[i-1]) * 4;
                    hi = base;
                end
                NA4: begin
                    lo = base;
                    hi = base + 4;
                end
                NAPOT: begin
                    t = 0;
                    while (t < 32 && conf_addr[i][t]) t++;
                    size = 64'd1 << (t + 3);
                    lo = (base / size) * size;
                    hi = lo + size;
                end
                default: ;
            endcase
            if (a >= lo && a < hi) begin
                r.hit       = 1'b1;
                r.entry_idx = 6'(i);
                r.allow     = ((acc & ~pmpconf[i].access_type) == 3'b000);
                if (dmpconf[i].domain != DOMI && dom != DOMI &&
                    dmpconf[i].domain != dom) r.allow = 1'b0;
                return r;
            end
        end
        r.allow = (pv == PRIV_LVL_M);
        return r;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            mv[p] = 1'b0;
            mr[p] = '0;
        end
        fv   = 1'b0;
        fa   = '0;
        fp   = 0;
        fd   = '0;
        mcnt = 0;
    endtask

    task automatic cycle();
        logic [NP-1:0] rdy;
        pmp_dmp_resp_t r;
        int nd;
        int first;
        #1;
        for (int p = 0; p < NP; p++)
            rdy[p] = !cfg_update && (!mv[p] || resp_ready[p]);
        chk("req_ready", 64'(req_ready), 64'(rdy));
        nd    = 0;
        first = -1;
        for (int p = 0; p < NP; p++) begin
            if (req_valid[p] && rdy[p]) begin
                r = ref_lookup(64'(req_addr[p]), req_access[p], req_priv[p], req_dom[p]);
                mv[p] = 1'b1;
                mr[p] = r;
                if (!r.allow) begin
                    nd++;
                    if (first < 0) first = p;
                end
            end else if (resp_ready[p]) begin
                mv[p] = 1'b0;
            end
        end
        if (fault_clear) mcnt = 0;
        mcnt = (mcnt + nd > 65535) ? 65535 : mcnt + nd;
        if (nd > 0 && (!fv || fault_clear)) begin
            fv = 1'b1;
            fa = req_addr[first];
            fp = first;
            fd = req_dom[first];
        end else if (fault_clear) begin
            fv = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("resp_valid%0d", p), 64'(resp_valid[p]), 64'(mv[p]));
            if (mv[p])
                chk($sformatf("resp%0d", p), 64'(resp[p]), 64'(mr[p]));
        end
        chk("fault_valid", 64'(fault_valid), 64'(fv));
        if (fv) begin
            chk("fault_addr", 64'(fault_addr), 64'(fa));
            chk("fault_port", 64'(fault_port), 64'(fp));
            chk("fault_dom", 64'(fault_dom), 64'(fd));
        end
        chk("fault_cnt", 64'(fault_cnt), 64'(mcnt));
    endtask

    task automatic idle();
        req_valid   = '0;
        resp_ready  = '1;
        cfg_update  = 1'b0;
        fault_clear = 1'b0;
        s_valid     = '0;
        z_valid     = '0;
    endtask

    task automatic req(int p, logic [33:0] a, pmp_access_t acc,
                       priv_lvl_t pv, dmp_domain_t d);
        req_valid[p]  = 1'b1;
        req_addr[p]   = a;
        req_access[p] = acc;
        req_priv[p]   = pv;
        req_dom[p]    = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'h3);
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_resp", 64'(resp), 64'h0);
        chk("rst_fault_valid", 64'(fault_valid), 64'h0);
        chk("rst_fault_addr", 64'(fault_addr), 64'h0);
        chk("rst_fault_port", 64'(fault_port), 64'h0);
        chk("rst_fault_dom", 64'(fault_dom), 64'h0);
        chk("rst_fault_cnt", 64'(fault_cnt), 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_cfg();
        for (int i = 0; i < NEN; i++) begin
            conf_addr[i]           = $urandom_range(0, 'h500);
            pmpconf[i].locked      = ($urandom_range(0, 3) == 0);
            pmpconf[i].reserved    = 2'b00;
            pmpconf[i].addr_mode   = pmp_addr_mode_t'($urandom_range(0, 3));
            pmpconf[i].access_type = pmp_access_t'($urandom_range(0, 7));
            dmpconf[i]             = {4'h0, 4'($urandom_range(0, 3))};
        end
    endtask

    pmp_dmp_resp_t held;
    int            k;

    initial begin
        req_addr   = '0;
        req_access = '0;
        req_priv   = {PRIV_LVL_U, PRIV_LVL_U};
        req_dom    = '0;
        conf_addr  = '0;
        pmpconf    = '0;
        dmpconf    = '0;
        s_addr     = '0;
        s_acc      = ACCESS_READ;
        s_priv     = PRIV_LVL_U;
        s_dom      = '0;
        s_conf     = '0;
        s_pcfg     = '0;
        s_dcfg     = '0;
        s_rready   = '1;
        z_addr     = 34'h100;
        z_acc      = ACCESS_WRITE;
        z_priv     = PRIV_LVL_U;
        z_dom      = 4'h3;
        idle();
        do_reset();

        // entry0: NAPOT 4 KiB at 0x8000_0000, RW, domain 2
        conf_addr[0] = 32'h2000_01FF;
        pmpconf[0]   = {1'b0, 2'b00, NAPOT, ACCESS_READ | ACCESS_WRITE};
        dmpconf[0]   = {4'h0, 4'h2};
        req(0, 34'h0_8000_0010, ACCESS_READ, PRIV_LVL_U, 4'h2);
        cycle();
        chk("t1_allow", 64'(resp[0].allow), 64'h1);
        chk("t1_hit", 64'(resp[0].hit), 64'h1);
        chk("t1_idx", 64'(resp[0].entry_idx), 64'h0);

        req(0, 34'h0_8000_0010, ACCESS_READ, PRIV_LVL_U, 4'h3);
        cycle();
        chk("t2_allow", 64'(resp[0].allow), 64'h0);
        chk("t2_faddr", 64'(fault_addr), 64'h8000_0010);
        chk("t2_fdom", 64'(fault_dom), 64'h3);
        chk("t2_cnt", 64'(fault_cnt), 64'h1);
        req(0, 34'h0_8000_0010, ACCESS_READ, PRIV_LVL_U, DOMI);
        cycle();
        chk("t3_allow", 64'(resp[0].allow), 64'h1);

        // M-mode skips unlocked entries until entry0 gets locked R-only
        conf_addr[1] = 32'h400;
        pmpconf[1]   = {1'b0, 2'b00, NA4, ACCESS_READ};
        req(0, 34'h1000, ACCESS_WRITE, PRIV_LVL_M, 4'h1);
        cycle();
        chk("t4_allow", 64'(resp[0].allow), 64'h1);
        chk("t4_hit", 64'(resp[0].hit), 64'h0);
        pmpconf[0] = {1'b1, 2'b00, NAPOT, ACCESS_READ};
        req(0, 34'h0_8000_0020, ACCESS_WRITE, PRIV_LVL_M, 4'h2);
        cycle();
        chk("t5_allow", 64'(resp[0].allow), 64'h0);
        chk("t5_idx", 64'(resp[0].entry_idx), 64'h0);
        chk("t5_faddr_kept", 64'(fault_addr), 64'h8000_0010);
        idle();

        fault_clear = 1'b1;
        cycle();
        fault_clear = 1'b0;
        req(0, 34'h10, ACCESS_READ, PRIV_LVL_U, 4'h0);
        req(1, 34'h20, ACCESS_READ, PRIV_LVL_U, 4'h0);
        cycle();
        chk("t6_fport", 64'(fault_port), 64'h0);
        chk("t6_faddr", 64'(fault_addr), 64'h10);
        chk("t6_cnt", 64'(fault_cnt), 64'h2);
        idle();
        req(1, 34'h30, ACCESS_READ, PRIV_LVL_U, 4'h0);
        cycle();
        chk("t7_faddr_kept", 64'(fault_addr), 64'h10);
        fault_clear = 1'b1;
        req(1, 34'h40, ACCESS_READ, PRIV_LVL_U, 4'h1);
        cycle();
        chk("t8_fport", 64'(fault_port), 64'h1);
        chk("t8_faddr", 64'(fault_addr), 64'h40);
        chk("t8_cnt", 64'(fault_cnt), 64'h1);
        idle();
        cycle();

        // Back-pressure: result held while resp_ready is low
        req(0, 34'h0_8000_0004, ACCESS_READ, PRIV_LVL_U, 4'h2);
        cycle();
        held = resp[0];
        resp_ready[0] = 1'b0;
        req(0, 34'h0_8000_0008, ACCESS_WRITE, PRIV_LVL_U, 4'h2);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_resp", 64'(resp[0]), 64'(held));
            chk("hold_ready", 64'(req_ready[0]), 64'h0);
        end
        resp_ready[0] = 1'b1;
        cycle();
        idle();
        cycle();
        cfg_update = 1'b1;
        #1;
        chk("cfg_upd_ready", 64'(req_ready), 64'h0);
        cycle();
        cfg_update = 1'b0;
        #1;
        chk("cfg_upd_after", 64'(req_ready), 64'h3);

        // Counter saturation on a 2-bit instance, and the zero-entry instance
        s_valid = 1'b1;
        z_valid = 1'b1;
        for (k = 1; k <= 5; k++) begin
            cycle();
            chk("sat_cnt", 64'(s_cnt), 64'((k > 3) ? 3 : k));
            chk("sat_allow", 64'(s_resp[0].allow), 64'h0);
            chk("zero_valid", 64'(z_rvalid), 64'h1);
            chk("zero_allow", 64'(z_resp[0].allow), 64'h1);
            chk("zero_hit", 64'(z_resp[0].hit), 64'h0);
        end
        idle();

        // Random traffic against the reference model
        for (int it = 0; it < 600; it++) begin
            if (it % 60 == 0) rand_cfg();
            for (int p = 0; p < NP; p++) begin
                req_valid[p]  = ($urandom_range(0, 3) != 0);
                req_addr[p]   = 34'($urandom_range(0, 'h1400));
                req_access[p] = pmp_access_t'($urandom_range(0, 7));
                k = $urandom_range(0, 2);
                req_priv[p]   = (k == 0) ? PRIV_LVL_U :
                                (k == 1) ? PRIV_LVL_S : PRIV_LVL_M;
                req_dom[p]    = 4'($urandom_range(0, 3));
                resp_ready[p] = ($urandom_range(0, 3) != 0);
            end
            cfg_update  = ($urandom_range(0, 9) == 0);
            fault_clear = ($urandom_range(0, 15) == 0);
            cycle();
        end

        // Reset with responses pending drops them
        idle();
        req_valid = '1;
        resp_ready = '0;
        cycle();
        do_reset();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/pmp_dmp_checker.md
Name: pmp_dmp_checker

Overview:
- Registered, multi-port successor to the combinational PMP/DMP permission check.
- Serves NR_PORTS independent request channels with valid/ready handshakes and one-cycle latency. Reports allow/deny and the matching entry index per response.
- Shared entry config is sized by NR_ENTRIES (up to 64). The block also keeps a sticky first-fault record and a saturating denial counter for the CSR/trap logic.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration
- PLEN, 34, physical address width
- PMP_LEN, 32, pmpaddr register width
- NR_ENTRIES, 16, number of PMP/DMP entries, 0..64
- NR_PORTS, 2, number of independent request channels, 1..4
- CNT_W, 16, denial counter width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NR_PORTS  request valid per port
- req_ready_o  out  NR_PORTS  request ready per port
- req_addr_i  in  NR_PORTS x PLEN  physical address
- req_access_i  in  NR_PORTS x riscv::pmp_access_t  access type
- req_priv_i  in  NR_PORTS x riscv::priv_lvl_t  privilege level
- req_dom_i  in  NR_PORTS x riscv::dmp_domain_t  expected domain
- resp_valid_o  out  NR_PORTS  response valid
- resp_ready_i  in  NR_PORTS  response accepted
- resp_o  out  NR_PORTS x pmp_dmp_resp_t  {allow, hit, entry_idx}
- conf_addr_i  in  NR_ENTRIES x PMP_LEN  pmpaddr values
- pmpconf_i  in  NR_ENTRIES x riscv::pmpcfg_t  pmpcfg values
- dmpconf_i  in  NR_ENTRIES x riscv::dmpcfg_t  dmpcfg values
- cfg_update_i  in  1  CSR write to any pmp/dmp register this cycle
- fault_valid_o  out  1  fault record holds a denial
- fault_addr_o  out  PLEN  address of first recorded denial
- fault_port_o  out  clog2(NR_PORTS)  port of that denial
- fault_dom_o  out  riscv::dmp_domain_t  expected domain of that denial
- fault_clear_i  in  1  clear fault record and counter
- fault_cnt_o  out  CNT_W  saturating count of denied responses

Behaviour:
- Reset: req_ready_o is all-ones and every other output is 0. This includes resp_valid_o, resp_o, fault_* and fault_cnt_o.
- Per-port handshake: req_ready_o[p] = !cfg_update_i && (!resp_valid_o[p] || resp_ready_i[p]). A request is accepted when valid and ready are both high.
- Latency: an accepted request's result appears the next cycle in resp_o[p] with resp_valid_o[p]=1. It holds stable until resp_ready_i[p]. Back-to-back throughput is one request per cycle per port.
- A result already registered before cfg_update_i stays valid and unchanged.
- Lookup per port:
  - Scan entries in ascending index order.
  - Skip an entry unless priv != M or pmpconf.locked.
  - The first entry whose address matches (OFF/TOR/NA4/NAPOT, TOR lower bound = previous entry's address, 0 for entry 0) is the hit. Set hit=1 and entry_idx to its index.
  - Deny the hit if the requested access bits are not a subset of the entry's access bits.
  - Also deny if entry domain != DOMI, expected domain != DOMI and the two domains differ.
  - Otherwise allow.
- No hit: allow only when priv == M. In that case hit=0 and entry_idx=0.
- NR_ENTRIES == 0: every response has allow=1 and hit=0, and the handshake is unchanged.
- Fault capture:
  - Evaluated on the cycle a denied result is registered, not on response acceptance.
  - The record is written only when fault_valid_o=0, or when fault_clear_i is asserted in the same cycle. A new fault wins over clear.
  - Simultaneous denials on several ports: the lowest port index is recorded.
- Counter: fault_cnt_o increments by the number of denied results registered this cycle and saturates at 2^CNT_W-1. fault_clear_i zeroes it first, then the current cycle's denials are added.
- Reset mid-operation drops all pending responses. There is no replay.

Decomposition:
- pmp_dmp_pkg holds:
  - pmp_dmp_resp_t {allow, hit, entry_idx[5:0]}
  - MAX_ENTRIES = 64, MAX_PORTS = 4
  - a function returning 1 when a domain pair is permitted under the DOMI wildcard rule
- Sub-module pmp_dmp_lookup: combinational priority scan instantiated once per port, reusing the existing pmp_entry per entry.
- The checker owns the port registers, handshake, fault record and counter.

Test Plan:
- U-mode, entry0 NAPOT 0x8000_0000/4KiB RW, dom 2. Port0 R at 0x8000_0010 with dom 2 -> next cycle resp valid, allow=1, hit=1, idx=0, fault_cnt=0.
- Same entry, request dom 3 -> allow=0, fault_valid=1, fault_addr=0x8000_0010, fault_dom=3, cnt=1. The same request with dom DOMI -> allow=1.
- M-mode with unlocked entries matching, write to 0x1000 -> allow=1, hit=0. Lock entry0 (R only) and write inside it -> allow=0, idx=0.
- Both ports denied in the same cycle (port0 addr 0x10, port1 addr 0x20) -> fault_port=0, addr=0x10, cnt +2. A later denial leaves the record unchanged. fault_clear plus a new denial in the same cycle -> the new record is captured and cnt=1.
- Hold resp_ready_i=0 for 3 cycles -> resp_o stable and req_ready_o=0. A cfg_update_i pulse while idle -> req_ready_o=0 that cycle only.
- CNT_W=2, five denials -> fault_cnt_o saturates at 3. NR_ENTRIES=0 -> U-mode request allowed.
